mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-ported, variable-latency memory between the core's instruction-fetch port and data port. Data requests have priority, with a bounded burst so that fetch is never starved. A watchdog terminates accesses the memory never acknowledges. A combined stall output lets the pipelined core freeze its PC and pipeline registers while an access is outstanding.

Parameters:
ADDR_W, 32, byte-address width on all ports
DATA_W, 32, data width
MAX_D_BURST, 4, consecutive data grants allowed while a fetch is pending
TIMEOUT_CYCLES, 64, WAIT cycles without mem_ack before forced termination
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk  in  1  clock; single clock domain
reset  in  1  asynchronous, active-low reset
i_req  in  1  instruction fetch request (core iaddr valid)
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched instruction (core idata)
i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid
d_r  in  1  data read request
d_w  in  1  data write request
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data (core ddata_r)
d_ready  out  1  one-cycle pulse: data access complete
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  write enable, qualified by mem_req
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory acknowledge, sampled only while mem_req=1
core_stall  out  1  (i_req & ~i_ready) | ((d_r|d_w) & ~d_ready), combinational
bus_err  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset values:
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata = 0.
  - i_rdata = 32'h00000013 (NOP); d_rdata = 0.
  - i_ready, d_ready, bus_err = 0.
  - burst_cnt, wd_cnt = 0.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight access is abandoned and no ready is pulsed.
- States: IDLE -> WAIT -> DONE -> IDLE.
- IDLE grant rule, evaluated every cycle:
  - d_req = d_r|d_w. If d_r and d_w are both high, treat the access as a write.
  - Grant D if d_req & (burst_cnt < MAX_D_BURST | ~i_req).
  - Else grant I if i_req.
  - Else stay in IDLE.
- On grant:
  - Register address, wdata and we (I grant: we=0) and the granted owner.
  - mem_req=1 from the next cycle; go to WAIT.
- burst_cnt:
  - D grant with i_req=1: increment, saturating at MAX_D_BURST.
  - D grant with i_req=0: clear.
  - I grant: clear.
- WAIT:
  - mem_req stays high and addr/wdata/we stay stable.
  - wd_cnt increments every WAIT cycle.
  - On mem_ack=1: drop mem_req. For a read, capture mem_rdata into the owner's rdata register. Go to DONE.
  - On wd_cnt == TIMEOUT_CYCLES-1 without ack: drop mem_req, load ERR_DATA into the owner's rdata (reads only), set bus_err, go to DONE.
  - ack and timeout in the same cycle: ack wins, bus_err is not set.
- DONE:
  - Owner's ready=1 for exactly this cycle; wd_cnt clears; next state IDLE.
  - The new grant is evaluated in the following IDLE cycle, so there are no back-to-back grants.
- Writes never modify d_rdata.
- The rdata registers hold their value until the next completion of the same owner.
- Minimum latency: req at cycle N (IDLE) -> mem_req at N+1 -> ack at N+1 -> ready at N+2. Throughput is one access per 3 cycles.
- Requesters must hold req/addr/data until ready. If a request is dropped mid-access, the access still completes and ready still pulses; the core ignores it.
- A requester that is not granted sees ready=0 and therefore stalls.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, WAIT, DONE}.
  - arb_owner_t enum {OWN_I, OWN_D}.
  - NOP_INSTR = 32'h00000013.
- One sub-module, mem_arb_watchdog: wd_cnt counter with clear/enable inputs and a timeout output, parameterised by TIMEOUT_CYCLES.
- Grant logic and FSM stay in the top module.

Test Plan:
- Fetch only: i_req=1, i_addr=0x10, ack 2 cycles after mem_req with rdata 0x00500093 -> i_ready pulses once with i_rdata=0x00500093. Address seen on mem_addr=0x10, mem_we=0.
- Simultaneous i_req and d_r (d_addr=0x100) -> data granted first: mem_addr=0x100, then 0x10. d_ready precedes i_ready; core_stall high until both complete.
- Starvation bound: i_req and d_w held high continuously with zero-wait ack -> exactly MAX_D_BURST=4 data writes, then one fetch; pattern repeats.
- Timeout: d_r with mem_ack tied 0 -> mem_req drops after 64 WAIT cycles. d_ready pulses with d_rdata=0xDEADBEEF; bus_err=1 and stays 1.
- Ack and timeout in the same cycle -> normal rdata is returned and bus_err stays 0.
- Reset pulse during WAIT -> mem_req=0 at once, state IDLE, no ready pulse, i_rdata=0x00000013. The next request proceeds normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - counts WAIT cycles and flags an unacknowledged access
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_q;
    logic [CW-1:0] wd_cnt_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (clr) begin
            wd_cnt_d = '0;
        end else if (en) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // Fires on the last permitted WAIT cycle so the FSM can terminate on this edge.
    assign timeout = en && (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one variable-latency memory port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                MAX_D_BURST    = 4,
    parameter int                TIMEOUT_CYCLES = 64,
    parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_r,
    input  logic              d_w,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              core_stall,
    output logic              bus_err
);

    localparam int BW = $clog2(MAX_D_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);

    arb_state_t        state_q,     state_d;
    arb_owner_t        owner_q,     owner_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              i_ready_q,   i_ready_d;
    logic              d_ready_q,   d_ready_d;
    logic              bus_err_q,   bus_err_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;

    logic              d_req;
    logic              wd_clr;
    logic              wd_en;
    logic              wd_timeout;
    logic [DATA_W-1:0] rd_val;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .en     (wd_en),
        .timeout(wd_timeout)
    );

    assign d_req = d_r | d_w;
    assign rd_val = mem_ack ? mem_rdata : ERR_DATA;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = bus_err_q;
        burst_cnt_d = burst_cnt_q;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Data wins unless it has used its burst allowance while a fetch waits.
                if (d_req && ((burst_cnt_q < BURST_MAX) || !i_req)) begin
                    owner_d     = OWN_D;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_we_d    = d_w;
                    mem_req_d   = 1'b1;
                    state_d     = WAIT;
                    if (i_req) begin
                        burst_cnt_d = (burst_cnt_q == BURST_MAX) ? burst_cnt_q
                                                                 : burst_cnt_q + 1'b1;
                    end else begin
                        burst_cnt_d = '0;
                    end
                end else if (i_req) begin
                    owner_d     = OWN_I;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = d_wdata;
                    mem_we_d    = 1'b0;
                    mem_req_d   = 1'b1;
                    state_d     = WAIT;
                    burst_cnt_d = '0;
                end
            end
            WAIT: begin
                wd_en = 1'b1;
                if (mem_ack || wd_timeout) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (!mem_we_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_d = rd_val;
                        end else begin
                            i_rdata_d = rd_val;
                        end
                    end
                    if (!mem_ack) begin
                        bus_err_d = 1'b1;
                    end
                    if (owner_q == OWN_D) begin
                        d_ready_d = 1'b1;
                    end else begin
                        i_ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                wd_clr  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= DATA_W'(NOP_INSTR);
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            bus_err_q   <= bus_err_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign i_ready    = i_ready_q;
    assign d_ready    = d_ready_q;
    assign bus_err    = bus_err_q;
    assign core_stall = (i_req & ~i_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed checks of mem_arbiter against a transaction model
module tb_mem_arbiter;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          MAXB = 4;
    localparam int          TO   = 64;
    localparam logic [31:0] ERRV = 32'hDEADBEEF;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_r = 1'b0;
    logic          d_w = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          core_stall;
    logic          bus_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(MAXB), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERRV)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_r(d_r), .d_w(d_w), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .core_stall(core_stall), .bus_err(bus_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bounded wait expired at %0t", nm, $time);
    endtask

    // Transaction-level reference: one outstanding access, one idle cycle after each completion.
    bit          m_busy, m_cool, m_own_d;
    int          m_wait, m_burst;
    logic        e_req, e_we, e_iready, e_dready, e_err;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata, m_val;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_cool = 0; m_own_d = 0; m_wait = 0; m_burst = 0;
            e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
            e_irdata = NOP; e_drdata = 0; e_iready = 0; e_dready = 0; e_err = 0;
        end else begin
            e_iready = 0;
            e_dready = 0;
            if (m_busy) begin
                m_wait = m_wait + 1;
                if (mem_ack || m_wait == TO) begin
                    m_busy = 0; m_cool = 1; e_req = 0;
                    m_val = mem_ack ? mem_rdata : ERRV;
                    if (!e_we && m_own_d) e_drdata = m_val;
                    if (!e_we && !m_own_d) e_irdata = m_val;
                    if (!mem_ack) e_err = 1;
                    if (m_own_d) e_dready = 1; else e_iready = 1;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if ((d_r || d_w) && (m_burst < MAXB || !i_req)) begin
                m_busy = 1; m_own_d = 1; m_wait = 0; e_req = 1;
                e_addr = d_addr; e_we = d_w; e_wdata = d_wdata;
                m_burst = i_req ? ((m_burst + 1 > MAXB) ? MAXB : m_burst + 1) : 0;
            end else if (i_req) begin
                m_busy = 1; m_own_d = 0; m_wait = 0; e_req = 1;
                e_addr = i_addr; e_we = 0;
                m_burst = 0;
            end
        end
    end

    logic [31:0] ga_q[$];
    logic        gw_q[$];
    bit          prev_req = 0;
    int          req_hi = 0;
    int          ipulse = 0;
    int          dpulse = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_req", mem_req, e_req);
            if (e_req) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", mem_we, e_we);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("i_ready", i_ready, e_iready);
            chk("d_ready", d_ready, e_dready);
            chk("i_rdata", i_rdata, e_irdata);
            chk("d_rdata", d_rdata, e_drdata);
            chk("bus_err", bus_err, e_err);
            chk("core_stall", core_stall,
                (i_req & ~e_iready) | ((d_r | d_w) & ~e_dready));
            if (mem_req && !prev_req) begin
                ga_q.push_back(mem_addr);
                gw_q.push_back(mem_we);
                req_hi = 0;
            end
            if (mem_req) req_hi++;
            prev_req = mem_req;
            if (i_ready) ipulse++;
            if (d_ready) dpulse++;
        end
    end

    // Memory responder: lat_mode -2 random, -1 never acknowledge, >=0 fixed WAIT cycles before ack.
    int          lat_mode = 0;
    int          lat_cur = 0;
    int          rsp_cnt = 0;
    bit          fixed_rd = 0;
    logic [31:0] rd_val = 0;

    always @(posedge clk) begin
        #2;
        if (mem_req) begin
            if (rsp_cnt == 0) begin
                if (lat_mode == -2) lat_cur = ($urandom_range(0, 49) == 0) ? 100000 : $urandom_range(0, 3);
                else if (lat_mode == -1) lat_cur = 100000;
                else lat_cur = lat_mode;
            end
            mem_ack   = (rsp_cnt == lat_cur);
            mem_rdata = (mem_ack && fixed_rd) ? rd_val : $urandom;
            rsp_cnt++;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            rsp_cnt   = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        i_req = 0; d_r = 0; d_w = 0;
        reset = 0;
        step();
        step();
        reset = 1;
        ga_q.delete();
        gw_q.delete();
    endtask

    task automatic wait_ready(input bit is_d, input int lim, input string nm);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(is_d ? d_ready : i_ready) && n < lim);
        if (!(is_d ? d_ready : i_ready)) bound_fail(nm);
    endtask

    int ip0, ipr, t_i, t_d;
    bit i_pend, d_pend;
    int r;

    initial begin
        #1 reset = 0;
        #1;
        chk_en = 1;
        chk("rst_i_rdata", i_rdata, NOP);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_bus_err", bus_err, 0);
        step();
        reset = 1;

        // Fetch only, ack two cycles after mem_req rises.
        do_reset();
        lat_mode = 2; fixed_rd = 1; rd_val = 32'h00500093;
        ip0 = ipulse;
        i_req = 1; i_addr = 32'h10;
        wait_ready(0, 20, "fetch_wait");
        chk("fetch_rdata", i_rdata, 32'h00500093);
        i_req = 0;
        repeat (5) step();
        chk("fetch_pulses", ipulse - ip0, 1);
        chk("fetch_grants", ga_q.size(), 1);
        if (ga_q.size() >= 1) begin
            chk("fetch_addr", ga_q[0], 32'h10);
            chk("fetch_we", gw_q[0], 0);
        end

        // Simultaneous fetch and load: data first.
        do_reset();
        lat_mode = 0; fixed_rd = 0;
        i_req = 1; i_addr = 32'h10; d_r = 1; d_addr = 32'h100;
        t_i = -1; t_d = -1;
        for (int n = 0; n < 30 && (t_i < 0 || t_d < 0); n++) begin
            step();
            if (d_ready) begin t_d = n; d_r = 0; end
            if (i_ready) begin t_i = n; i_req = 0; end
        end
        if (t_i < 0 || t_d < 0) bound_fail("prio_wait");
        chk("prio_order", (t_d < t_i) ? 1 : 0, 1);
        chk("prio_gap", t_i - t_d, 3);
        if (ga_q.size() >= 2) begin
            chk("prio_first", ga_q[0], 32'h100);
            chk("prio_second", ga_q[1], 32'h10);
        end else bound_fail("prio_grants");

        // Starvation bound: continuous fetch and store traffic.
        do_reset();
        lat_mode = 0;
        i_req = 1; i_addr = 32'h20; d_w = 1; d_addr = 32'h300; d_wdata = 32'hCAFE0001;
        for (int n = 0; n < 100 && ga_q.size() < 10; n++) step();
        i_req = 0; d_w = 0;
        if (ga_q.size() < 10) bound_fail("burst_wait");
        else for (int k = 0; k < 10; k++) chk($sformatf("burst_we%0d", k), gw_q[k], (k % 5) != 4);
        repeat (4) step();

        // Ack arriving in the last permitted WAIT cycle beats the watchdog.
        do_reset();
        lat_mode = TO - 1; fixed_rd = 1; rd_val = 32'h12345678;
        d_r = 1; d_addr = 32'h200;
        wait_ready(1, 100, "edge_wait");
        d_r = 0;
        chk("edge_rdata", d_rdata, 32'h12345678);
        chk("edge_err", bus_err, 0);
        chk("edge_wait_len", req_hi, TO);

        // No ack at all.
        step();
        lat_mode = -1;
        d_r = 1; d_addr = 32'h204;
        wait_ready(1, 100, "to_wait");
        d_r = 0;
        chk("to_rdata", d_rdata, ERRV);
        chk("to_err", bus_err, 1);
        chk("to_wait_len", req_hi, TO);
        repeat (5) step();
        chk("to_err_sticky", bus_err, 1);

        // Reset in the middle of WAIT.
        lat_mode = -1; fixed_rd = 1; rd_val = 32'h00A00113;
        i_req = 1; i_addr = 32'h40;
        for (int n = 0; n < 10 && !mem_req; n++) step();
        repeat (3) step();
        ipr = ipulse;
        #1 reset = 0;
        #1;
        chk("rstw_mem_req", mem_req, 0);
        chk("rstw_i_rdata", i_rdata, NOP);
        chk("rstw_bus_err", bus_err, 0);
        lat_mode = 1;
        step();
        reset = 1;
        chk("rstw_no_pulse", ipulse - ipr, 0);
        wait_ready(0, 20, "rstw_wait");
        chk("rstw_next_rdata", i_rdata, 32'h00A00113);
        i_req = 0;
        step();

        // Randomized traffic with random latencies and occasional timeouts.
        lat_mode = -2; fixed_rd = 0;
        i_pend = 0; d_pend = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (i_ready) i_pend = 0;
            if (d_ready) d_pend = 0;
            if (!i_pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    i_req = 1; i_addr = $urandom & 32'h0000FFFC; i_pend = 1;
                end else i_req = 0;
            end
            if (!d_pend) begin
                r = $urandom_range(0, 5);
                d_r = (r == 1 || r == 3);
                d_w = (r == 2 || r == 3);
                if (d_r || d_w) begin
                    d_addr = $urandom & 32'h0000FFFC; d_wdata = $urandom; d_pend = 1;
                end
            end
        end
        for (int n = 0; n < 200 && (i_pend || d_pend); n++) begin
            step();
            if (i_ready) begin i_pend = 0; i_req = 0; end
            if (d_ready) begin d_pend = 0; d_r = 0; d_w = 0; end
        end
        if (i_pend || d_pend) bound_fail("drain_wait");
        i_req = 0; d_r = 0; d_w = 0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
